// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared definitions for the rv32i_cpu single-cycle core: opcode and funct3
// constants, the ALU-operation and immediate-type enums, the decoded control
// bundle, and helper functions for immediate generation and the ALU.
// No ports (package).

package rv32i_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load/store funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  typedef struct packed {
    alu_op_e   alu_op;
    imm_type_e imm_type;
    logic      src_a_pc;
    logic      src_b_imm;
    logic      reg_we;
    logic      mem_we;
    wb_sel_e   wb_sel;
    logic      branch;
    logic      jal;
    logic      jalr;
  } ctrl_t;

  // Only instr[31:7] carries immediate bits in any format.
  function automatic logic [31:0] imm_gen(input logic [31:7] ib, input imm_type_e t);
    logic [31:0] r;
    case (t)
      IMM_I:   r = {{20{ib[31]}}, ib[31:20]};
      IMM_S:   r = {{20{ib[31]}}, ib[31:25], ib[11:7]};
      IMM_B:   r = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
      IMM_U:   r = {ib[31:12], 12'd0};
      IMM_J:   r = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  // alt selects SUB/SRA; the caller only raises it where instr[30] is a funct7 bit.
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e r;
    case (f3)
      F3_ADD_SUB: r = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     r = ALU_SLL;
      F3_SLT:     r = ALU_SLT;
      F3_SLTU:    r = ALU_SLTU;
      F3_XOR:     r = ALU_XOR;
      F3_SRL_SRA: r = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      r = ALU_OR;
      default:    r = ALU_AND;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:    r = a + b;
      ALU_SUB:    r = a - b;
      ALU_SLL:    r = a << b[4:0];
      ALU_SLT:    r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:   r = {31'd0, a < b};
      ALU_XOR:    r = a ^ b;
      ALU_SRL:    r = a >> b[4:0];
      ALU_SRA:    r = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     r = a | b;
      ALU_AND:    r = a & b;
      ALU_PASS_B: r = b;
      default:    r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// rv32i_regfile
// 32 x 32-bit integer register file: two combinational read ports, one
// synchronous write port. x0 always reads 0 and ignores writes. All registers
// clear on asynchronous active-low reset.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   ra1, ra2   read addresses      rd1, rd2  read data
//   we, wa, wd write enable / address / data

module rv32i_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] mem [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && wa != 5'd0) begin
      mem[wa] <= wd;
    end
  end

  // Reads see the pre-edge value, so a same-cycle write is not forwarded.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : mem[ra2];

endmodule

// File: rtl/rv32i_cpu.sv
// rv32i_cpu
// Single-cycle RV32I core with internal instruction and data memories. Every
// rising edge retires one instruction: PC, register write and store commit
// together. Hierarchy: instr_mem.imem (byte array), dp.regfile.mem,
// dp.datamem.mem (word array).
// The program image named by IMEM_INIT is placed into instr_mem.imem by the
// surrounding environment; imem is never written by the core or by reset.
// Parameters: IMEM_BYTES, DMEM_WORDS (both powers of two), IMEM_INIT.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active low
// Build option: define RV32I_TRACE_EN to print a retirement trace.

module rv32i_cpu
  import rv32i_pkg::*;
#(
  parameter int    IMEM_BYTES = 512,
  parameter int    DMEM_WORDS = 128,
  parameter string IMEM_INIT  = "program.hex"
) (
  input logic clk,
  input logic rst
);

  localparam int IMEM_AW = $clog2(IMEM_BYTES);
  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= '0;
    else      pc_q <= pc_d;
  end

  if (1) begin : instr_mem
    logic [7:0]         imem [IMEM_BYTES];
    logic [IMEM_AW-1:0] fa0, fa1, fa2, fa3;

    // Fetch address wraps within the memory, including the upper bytes of a word.
    always_comb begin
      fa0   = pc_q[IMEM_AW-1:0];
      fa1   = fa0 + IMEM_AW'(1);
      fa2   = fa0 + IMEM_AW'(2);
      fa3   = fa0 + IMEM_AW'(3);
      instr = {imem[fa3], imem[fa2], imem[fa1], imem[fa0]};
    end
  end

  if (1) begin : dp
    ctrl_t              ctrl;
    logic               op_legal;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [31:0]        rs1_val, rs2_val, imm, alu_a, alu_b, alu_res;
    logic [31:0]        wb_data, load_val, rword, store_data;
    logic [3:0]         store_mask;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic               br_taken;
    logic [DMEM_AW-1:0] word_idx;

    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Control decode; anything not recognised leaves every enable low so it
    // only advances the PC.
    always_comb begin
      ctrl          = '0;
      ctrl.alu_op   = ALU_ADD;
      ctrl.imm_type = IMM_I;
      ctrl.wb_sel   = WB_ALU;
      op_legal      = 1'b0;
      case (instr[6:0])
        OPC_LUI: begin
          ctrl.reg_we    = 1'b1;
          ctrl.imm_type  = IMM_U;
          ctrl.src_b_imm = 1'b1;
          ctrl.alu_op    = ALU_PASS_B;
        end
        OPC_AUIPC: begin
          ctrl.reg_we    = 1'b1;
          ctrl.imm_type  = IMM_U;
          ctrl.src_a_pc  = 1'b1;
          ctrl.src_b_imm = 1'b1;
        end
        OPC_JAL: begin
          ctrl.reg_we   = 1'b1;
          ctrl.imm_type = IMM_J;
          ctrl.jal      = 1'b1;
          ctrl.wb_sel   = WB_PC4;
        end
        OPC_JALR: begin
          if (funct3 == 3'b000) begin
            ctrl.reg_we    = 1'b1;
            ctrl.src_b_imm = 1'b1;
            ctrl.jalr      = 1'b1;
            ctrl.wb_sel    = WB_PC4;
          end
        end
        OPC_BRANCH: begin
          if (funct3 != 3'b010 && funct3 != 3'b011) begin
            ctrl.branch   = 1'b1;
            ctrl.imm_type = IMM_B;
          end
        end
        OPC_LOAD: begin
          if (funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
              funct3 == F3_LBU || funct3 == F3_LHU) begin
            ctrl.reg_we    = 1'b1;
            ctrl.src_b_imm = 1'b1;
            ctrl.wb_sel    = WB_MEM;
          end
        end
        OPC_STORE: begin
          if (funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW) begin
            ctrl.mem_we    = 1'b1;
            ctrl.imm_type  = IMM_S;
            ctrl.src_b_imm = 1'b1;
          end
        end
        OPC_OP_IMM: begin
          if (funct3 == F3_SLL)          op_legal = (funct7 == 7'b0000000);
          else if (funct3 == F3_SRL_SRA) op_legal = (funct7 == 7'b0000000 || funct7 == 7'b0100000);
          else                           op_legal = 1'b1;
          if (op_legal) begin
            ctrl.reg_we    = 1'b1;
            ctrl.src_b_imm = 1'b1;
            // For ADDI bit 30 belongs to the immediate, not to SUB.
            ctrl.alu_op    = alu_op_from_f3(funct3, (funct3 == F3_SRL_SRA) && funct7[5]);
          end
        end
        OPC_OP: begin
          op_legal = (funct7 == 7'b0000000) ||
                     (funct7 == 7'b0100000 && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA));
          if (op_legal) begin
            ctrl.reg_we = 1'b1;
            ctrl.alu_op = alu_op_from_f3(funct3, funct7[5]);
          end
        end
        default: ;
      endcase
    end

    rv32i_regfile regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (instr[19:15]),
      .ra2 (instr[24:20]),
      .we  (ctrl.reg_we),
      .wa  (instr[11:7]),
      .wd  (wb_data),
      .rd1 (rs1_val),
      .rd2 (rs2_val)
    );

    assign imm     = imm_gen(instr[31:7], ctrl.imm_type);
    assign alu_a   = ctrl.src_a_pc  ? pc_q : rs1_val;
    assign alu_b   = ctrl.src_b_imm ? imm  : rs2_val;
    assign alu_res = alu(ctrl.alu_op, alu_a, alu_b);

    always_comb begin
      br_taken = 1'b0;
      case (funct3)
        F3_BEQ:  br_taken = (rs1_val == rs2_val);
        F3_BNE:  br_taken = (rs1_val != rs2_val);
        F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
        F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
        F3_BLTU: br_taken = (rs1_val <  rs2_val);
        F3_BGEU: br_taken = (rs1_val >= rs2_val);
        default: br_taken = 1'b0;
      endcase
    end

    // Targets are not alignment-checked; JALR clears only bit 0.
    always_comb begin
      pc_d = pc_q + 32'd4;
      if (ctrl.jal || (ctrl.branch && br_taken)) pc_d = pc_q + imm;
      else if (ctrl.jalr)                        pc_d = alu_res & ~32'd1;
    end

    // Word index wraps modulo the data memory; lane selection ignores the
    // low address bits a misaligned half/word access cannot use.
    assign word_idx = alu_res[DMEM_AW+1:2];
    assign byte_sel = rword[{alu_res[1:0], 3'b000} +: 8];
    assign half_sel = alu_res[1] ? rword[31:16] : rword[15:0];

    always_comb begin
      load_val = rword;
      case (funct3)
        F3_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
        F3_LH:   load_val = {{16{half_sel[15]}}, half_sel};
        F3_LBU:  load_val = {24'd0, byte_sel};
        F3_LHU:  load_val = {16'd0, half_sel};
        default: load_val = rword;
      endcase
    end

    always_comb begin
      store_data = rs2_val;
      store_mask = 4'b1111;
      case (funct3)
        F3_SB: begin
          store_data = {4{rs2_val[7:0]}};
          store_mask = 4'b0001 << alu_res[1:0];
        end
        F3_SH: begin
          store_data = {2{rs2_val[15:0]}};
          store_mask = alu_res[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end

    always_comb begin
      case (ctrl.wb_sel)
        WB_MEM:  wb_data = load_val;
        WB_PC4:  wb_data = pc_q + 32'd4;
        default: wb_data = alu_res;
      endcase
    end

    if (1) begin : datamem
      logic [31:0] mem [DMEM_WORDS];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DMEM_WORDS; i++) mem[i] <= '0;
        end else if (ctrl.mem_we) begin
          for (int b = 0; b < 4; b++) begin
            if (store_mask[b]) mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
          end
        end
      end

      assign rword = mem[word_idx];
    end

`ifdef RV32I_TRACE_EN
    always @(posedge clk) begin
      if (rst) begin
        $display("pc=%08h instr=%08h", pc_q, instr);
        if (ctrl.reg_we && instr[11:7] != 5'd0)
          $display("  x%0d <= %08h", instr[11:7], wb_data);
        if (ctrl.mem_we)
          $display("  store addr=%08h data=%08h lanes=%b", alu_res, store_data, store_mask);
      end
    end
`endif
  end

endmodule

// File: tb/tb_rv32i_cpu.sv
// tb_rv32i_cpu
// Directed program for rv32i_cpu: the program is written straight into
// instr_mem.imem, then architectural state is inspected hierarchically after
// each retiring edge against hand-computed values.

module tb_rv32i_cpu;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  rv32i_cpu #(
    .IMEM_BYTES (512),
    .DMEM_WORDS (128),
    .IMEM_INIT  ("program.hex")
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction encoders (bench-side, independent of the RTL package)
  function automatic logic [31:0] encI(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
    logic [31:0] im;
    im = imm;
    return {im[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encS(input int imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3);
    logic [31:0] im;
    im = imm;
    return {im[11:5], rs2, rs1, f3, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] encB(input int imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] encJ(input int imm, input logic [4:0] rd);
    logic [31:0] im;
    im = imm;
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic putWord(input int addr, input logic [31:0] w);
    dut.instr_mem.imem[addr]     = w[7:0];
    dut.instr_mem.imem[addr + 1] = w[15:8];
    dut.instr_mem.imem[addr + 2] = w[23:16];
    dut.instr_mem.imem[addr + 3] = w[31:24];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %08h, expected %08h", tag, got, exp);
  endtask

  // Advance n retiring edges, then settle just after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] xr(input int i);
    return dut.dp.regfile.mem[i];
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] acc;
    checkCount = 0;
    passCount  = 0;

    rst = 1'b1;
    #1 rst = 1'b0;

    for (int a = 0; a < 512; a++) dut.instr_mem.imem[a] = 8'h00;
    putWord(32'h00, encI(5, 0, 3'b000, 1, 7'h13));       // ADDI x1,x0,5
    putWord(32'h04, encI(-7, 1, 3'b000, 2, 7'h13));      // ADDI x2,x1,-7
    putWord(32'h08, encI(9, 0, 3'b000, 0, 7'h13));       // ADDI x0,x0,9
    putWord(32'h0C, encS(0, 2, 0, 3'b010));              // SW x2,0(x0)
    putWord(32'h10, encI(0, 0, 3'b000, 3, 7'h03));       // LB x3,0(x0)
    putWord(32'h14, encI(1, 0, 3'b100, 4, 7'h03));       // LBU x4,1(x0)
    putWord(32'h18, encI(2, 0, 3'b001, 5, 7'h03));       // LH x5,2(x0)
    putWord(32'h1C, encS(1, 1, 0, 3'b000));              // SB x1,1(x0)
    putWord(32'h20, encJ(12, 1));                        // JAL x1,+12
    putWord(32'h24, encI(1, 0, 3'b000, 9, 7'h13));       // skipped
    putWord(32'h28, encI(2, 0, 3'b000, 9, 7'h13));       // skipped
    putWord(32'h2C, encI(32'h41, 0, 3'b000, 1, 7'h13));  // ADDI x1,x0,0x41
    putWord(32'h30, encI(0, 1, 3'b000, 0, 7'h67));       // JALR x0,0(x1) -> 0x40
    putWord(32'h34, encI(3, 0, 3'b000, 9, 7'h13));       // skipped
    putWord(32'h38, encI(3, 0, 3'b000, 9, 7'h13));       // skipped
    putWord(32'h3C, encI(3, 0, 3'b000, 9, 7'h13));       // skipped
    putWord(32'h40, encI(5, 0, 3'b000, 1, 7'h13));       // ADDI x1,x0,5
    putWord(32'h44, encB(8, 1, 2, 3'b100));              // BLT x2,x1,+8 (taken)
    putWord(32'h48, encI(1, 0, 3'b000, 10, 7'h13));      // skipped
    putWord(32'h4C, encB(8, 1, 2, 3'b110));              // BLTU x2,x1,+8 (not taken)
    putWord(32'h50, encU(20'h80000, 6, 7'h37));          // LUI x6,0x80000
    putWord(32'h54, encI(32'h404, 6, 3'b101, 7, 7'h13)); // SRAI x7,x6,4
    putWord(32'h58, encI(4, 6, 3'b101, 11, 7'h13));      // SRLI x11,x6,4
    putWord(32'h5C, encR(7'h00, 0, 6, 3'b010, 8));       // SLT x8,x6,x0
    putWord(32'h60, encR(7'h00, 0, 6, 3'b011, 12));      // SLTU x12,x6,x0
    putWord(32'h64, encR(7'h20, 2, 1, 3'b000, 13));      // SUB x13,x1,x2
    putWord(32'h68, encU(20'h00001, 14, 7'h17));         // AUIPC x14,1
    putWord(32'h6C, encS(6, 1, 0, 3'b001));              // SH x1,6(x0)
    putWord(32'h70, encI(6, 0, 3'b101, 15, 7'h03));      // LHU x15,6(x0)
    putWord(32'h74, 32'h00000073);                       // ECALL
    putWord(32'h78, encJ(0, 0));                         // JAL x0,0 (park)

    #3;
    checkOutput("reset_pc", dut.pc_q, 32'h0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= xr(i);
    checkOutput("reset_regs", acc, 32'h0);

    @(negedge clk) rst = 1'b1;

    applyStimulus(1);
    checkOutput("addi_x1", xr(1), 32'h5);
    checkOutput("pc_after_1", dut.pc_q, 32'h4);
    applyStimulus(1);
    checkOutput("addi_neg_x2", xr(2), 32'hFFFFFFFE);
    applyStimulus(1);
    checkOutput("x0_write_dropped", xr(0), 32'h0);
    applyStimulus(1);
    checkOutput("sw_mem0", dut.dp.datamem.mem[0], 32'hFFFFFFFE);
    applyStimulus(1);
    checkOutput("lb_x3", xr(3), 32'hFFFFFFFE);
    applyStimulus(1);
    checkOutput("lbu_x4", xr(4), 32'h000000FF);
    applyStimulus(1);
    checkOutput("lh_x5", xr(5), 32'hFFFFFFFF);
    applyStimulus(1);
    checkOutput("sb_mem0", dut.dp.datamem.mem[0], 32'hFFFF05FE);
    applyStimulus(1);
    checkOutput("jal_link", xr(1), 32'h24);
    checkOutput("jal_pc", dut.pc_q, 32'h2C);
    applyStimulus(2);
    checkOutput("jalr_pc_lsb_cleared", dut.pc_q, 32'h40);
    applyStimulus(2);
    checkOutput("blt_taken_pc", dut.pc_q, 32'h4C);
    applyStimulus(1);
    checkOutput("bltu_not_taken_pc", dut.pc_q, 32'h50);
    applyStimulus(1);
    checkOutput("lui_x6", xr(6), 32'h80000000);
    applyStimulus(1);
    checkOutput("srai_x7", xr(7), 32'hF8000000);
    applyStimulus(1);
    checkOutput("srli_x11", xr(11), 32'h08000000);
    applyStimulus(1);
    checkOutput("slt_x8", xr(8), 32'h1);
    applyStimulus(1);
    checkOutput("sltu_x12", xr(12), 32'h0);
    applyStimulus(1);
    checkOutput("sub_x13", xr(13), 32'h7);
    applyStimulus(1);
    checkOutput("auipc_x14", xr(14), 32'h1068);
    applyStimulus(1);
    checkOutput("sh_mem1", dut.dp.datamem.mem[1], 32'h00050000);
    applyStimulus(1);
    checkOutput("lhu_x15", xr(15), 32'h5);
    applyStimulus(1);
    checkOutput("ecall_pc", dut.pc_q, 32'h78);
    applyStimulus(2);
    checkOutput("park_pc", dut.pc_q, 32'h78);
    checkOutput("skipped_x9", xr(9), 32'h0);
    checkOutput("skipped_x10", xr(10), 32'h0);

    // Reset asserted between edges must clear state without waiting for a clock.
    #2 rst = 1'b0;
    #1;
    checkOutput("midreset_pc", dut.pc_q, 32'h0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= xr(i);
    checkOutput("midreset_regs", acc, 32'h0);
    acc = '0;
    for (int i = 0; i < 128; i++) acc |= dut.dp.datamem.mem[i];
    checkOutput("midreset_dmem", acc, 32'h0);

    @(negedge clk) rst = 1'b1;
    applyStimulus(1);
    checkOutput("restart_x1", xr(1), 32'h5);
    checkOutput("restart_pc", dut.pc_q, 32'h4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rv32i_cpu.md
# rv32i_cpu

Single-cycle RV32I integer core with on-chip instruction and data memories; top of the processor hierarchy. Each rising clock edge retires exactly one instruction fetched from the internal instruction memory, updating PC, register file and data memory. No external bus: the program is preloaded from a hex file and results are observed hierarchically.

## Interface
- IMEM_BYTES, 512, instruction memory size in bytes (byte array `instr_mem.imem`)
- DMEM_WORDS, 128, data memory size in 32-bit words (word array `dp.datamem.mem`)
- IMEM_INIT, "program.hex", byte-wide hex file loaded into imem at time 0
- clk  input  1  sole clock, rising-edge active
- rst  input  1  reset; asynchronous and active-low (asserted at 0)

## Operation
- Reset asserted: PC=0, all 32 registers (`dp.regfile.mem[0..31]`) = 0, data memory cleared to 0; imem untouched.
- Fetch: instruction = imem[PC+3..PC], little-endian. PC bits above the memory size wrap (address taken modulo IMEM_BYTES).
- Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- FENCE, ECALL, EBREAK and any unrecognised encoding: no architectural effect except PC+=4.
- x0 reads 0 always; writes to x0 discarded.
- Arithmetic 32-bit modulo 2^32, no overflow flag; shifts use low 5 bits of rs2/shamt; SRA/SRAI sign-fill.
- Immediates per RV32I I/S/B/U/J formats, sign-extended to 32 bits.
- Next PC: branch taken -> PC+immB; JAL -> PC+immJ; JALR -> (rs1+immI) & ~1; else PC+4. JAL/JALR write PC+4 to rd.
- Loads/stores: address = rs1+imm, little-endian, word index = addr[31:2] modulo DMEM_WORDS; byte/halfword lanes selected by addr[1:0]. Misaligned halfword/word accesses use addr[1:0] forced to 0 (word) or addr[0] forced to 0 (half). LB/LH sign-extend, LBU/LHU zero-extend. Stores modify only the addressed lanes.
- Misaligned jump/branch targets are not trapped; fetch proceeds at target.

## Timing
- Single cycle: decode, execute, memory read combinational; PC, rd and data-memory writes commit on the same rising edge.
- Instruction i fetched at PC after edge n is complete after edge n+1; CPI = 1.
- Data memory read is combinational (load result available same cycle).
- Register file: two combinational reads, one synchronous write; read of a register written in the same cycle returns the old value.
- Reset asserting mid-cycle immediately forces PC/registers/dmem to reset values; first fetch at PC=0 after deassertion, first commit on the following rising edge.

## Configuration
- RV32I_TRACE_EN defined: on each retiring edge, $display PC, instruction word, and rd/value when a register is written, plus address/data on stores.
- Undefined: no simulation output; identical architectural behaviour.

## Structure
- Package rv32i_pkg: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM), funct3 constants, ALU-operation enum, immediate-type enum.
- Hierarchy: control unit (decode -> ALU op, imm type, write enable, mem size) plus datapath instance `dp` containing `regfile` and `datamem`; `instr_mem` at top. Natural single sub-module: rv32i_regfile.

## Test plan
- Reset then ADDI x1,x0,5; ADDI x2,x1,-7 -> x1=5, x2=0xFFFFFFFE after 2 edges; x0 write (ADDI x0,x0,9) leaves x0=0.
- SW x2,0(x0); LB x3,0(x0); LBU x4,1(x0); LH x5,2(x0) -> mem[0]=0xFFFFFFFE, x3=0xFFFFFFFE, x4=0xFF, x5=0xFFFFFFFF; then SB x1,1(x0) -> mem[0]=0xFFFF05FE.
- BLT x2,x1,+8 taken (signed -2<5) skips next instr; BLTU x2,x1,+8 not taken -> PC+4.
- JAL x1,+12 at PC=0x20 -> x1=0x24, PC=0x2C; JALR x0,0(x1) with x1=0x25 -> PC=0x24.
- LUI x6,0x80000; SRAI x7,x6,4 -> 0xF8000000; SRLI -> 0x08000000; SLT x8,x6,x0 -> 1; SLTU -> 0.
- Drive rst=0 mid-program -> PC, all registers, dmem read 0 immediately; release -> execution restarts at PC=0.
